// File: rtl/slave_serial_port.sv
// Serial bus slave front end: deserialises a start/address/rw/data frame, qualifies the
// address against the memory window, hands a parallel request to the core, serialises read data.
module slave_serial_port #(
   parameter int MEM_OFFSET     = 0,
   parameter int MEM_SIZE       = 2048,
   parameter int ADDRESS_WIDTH  = 12,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     serial_in,
   input  logic                     bus_busy,
   output logic                     serial_out,
   output logic                     serial_oe,
   output logic                     req_valid,
   output logic [ADDRESS_WIDTH-1:0] req_addr,
   output logic                     req_rw,
   output logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic                     req_ack,
   input  logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     timeout_err
);
   localparam int MAX_AD  = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
   localparam int MAX_ALL = (MAX_AD > TIMEOUT_CYCLES) ? MAX_AD : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(MAX_ALL + 1);
   localparam int AW1     = ADDRESS_WIDTH + 1;
   localparam int AW2     = ADDRESS_WIDTH + 2;
   localparam logic [CW-1:0]  ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
   localparam logic [CW-1:0]  DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW2-1:0] WIN_LO    = AW2'(MEM_OFFSET);
   localparam logic [AW1-1:0] WIN_SIZE  = AW1'(MEM_SIZE);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_RW       = 3'd2,
      ST_WDATA    = 3'd3,
      ST_REQ      = 3'd4,
      ST_TURN     = 3'd5,
      ST_RDATA    = 3'd6,
      ST_WAIT_REL = 3'd7
   } state_t;

   state_t                   state_r, state_s;
   logic [CW-1:0]            cnt_r, cnt_s;
   logic [ADDRESS_WIDTH-1:0] addr_sh_r, addr_sh_s;
   logic [DATA_WIDTH-1:0]    data_sh_r, data_sh_s;
   logic [DATA_WIDTH-1:0]    rd_sh_r, rd_sh_s;
   logic                     req_valid_r, req_valid_s;
   logic [ADDRESS_WIDTH-1:0] req_addr_r, req_addr_s;
   logic                     req_rw_r, req_rw_s;
   logic [DATA_WIDTH-1:0]    req_wdata_r, req_wdata_s;
   logic                     serial_out_r, serial_out_s;
   logic                     serial_oe_r, serial_oe_s;
   logic                     timeout_r, timeout_s;
   logic [AW2-1:0]           win_off_s;
   logic                     in_range_s;

   // Offset from the window base; the extra top bit is the borrow, so the window end never wraps.
   assign win_off_s  = {2'b00, addr_sh_r} - WIN_LO;
   assign in_range_s = !win_off_s[AW2-1] && (win_off_s[AW1-1:0] < WIN_SIZE);

   assign serial_out  = serial_out_r;
   assign serial_oe   = serial_oe_r;
   assign req_valid   = req_valid_r;
   assign req_addr    = req_addr_r;
   assign req_rw      = req_rw_r;
   assign req_wdata   = req_wdata_r;
   assign timeout_err = timeout_r;

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         addr_sh_r    <= '0;
         data_sh_r    <= '0;
         rd_sh_r      <= '0;
         req_valid_r  <= 1'b0;
         req_addr_r   <= '0;
         req_rw_r     <= 1'b0;
         req_wdata_r  <= '0;
         serial_out_r <= 1'b1;
         serial_oe_r  <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         addr_sh_r    <= addr_sh_s;
         data_sh_r    <= data_sh_s;
         rd_sh_r      <= rd_sh_s;
         req_valid_r  <= req_valid_s;
         req_addr_r   <= req_addr_s;
         req_rw_r     <= req_rw_s;
         req_wdata_r  <= req_wdata_s;
         serial_out_r <= serial_out_s;
         serial_oe_r  <= serial_oe_s;
         timeout_r    <= timeout_s;
      end
   end

   // Next-state and next-output logic; a dropped bus_busy outranks every other transition.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      addr_sh_s    = addr_sh_r;
      data_sh_s    = data_sh_r;
      rd_sh_s      = rd_sh_r;
      req_valid_s  = req_valid_r;
      req_addr_s   = req_addr_r;
      req_rw_s     = req_rw_r;
      req_wdata_s  = req_wdata_r;
      serial_out_s = serial_out_r;
      serial_oe_s  = serial_oe_r;
      timeout_s    = 1'b0;
      if ((state_r != ST_IDLE) && !bus_busy) begin
         state_s      = ST_IDLE;
         cnt_s        = '0;
         req_valid_s  = 1'b0;
         serial_oe_s  = 1'b0;
         serial_out_s = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!serial_in && bus_busy) begin
                  state_s = ST_ADDR;
                  cnt_s   = '0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ADDR: begin
               addr_sh_s = {addr_sh_r[ADDRESS_WIDTH-2:0], serial_in};
               if (cnt_r == ADDR_LAST) begin
                  state_s = ST_RW;
                  cnt_s   = '0;
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            ST_RW: begin
               req_rw_s = serial_in;
               cnt_s    = '0;
               if (!in_range_s) begin
                  state_s = ST_WAIT_REL;
               end else if (serial_in) begin
                  state_s = ST_WDATA;
               end else begin
                  state_s     = ST_REQ;
                  req_valid_s = 1'b1;
                  req_addr_s  = addr_sh_r;
                  req_wdata_s = '0;
               end
            end
            ST_WDATA: begin
               data_sh_s = {data_sh_r[DATA_WIDTH-2:0], serial_in};
               if (cnt_r == DATA_LAST) begin
                  state_s     = ST_REQ;
                  cnt_s       = '0;
                  req_valid_s = 1'b1;
                  req_addr_s  = addr_sh_r;
                  req_wdata_s = {data_sh_r[DATA_WIDTH-2:0], serial_in};
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            ST_REQ: begin
               if (req_ack) begin
                  req_valid_s = 1'b0;
                  if (req_rw_r) begin
                     state_s = ST_WAIT_REL;
                  end else begin
                     state_s = ST_TURN;
                     rd_sh_s = rsp_rdata;
                  end
               end else if (cnt_r == TO_LAST) begin
                  state_s     = ST_WAIT_REL;
                  req_valid_s = 1'b0;
                  timeout_s   = 1'b1;
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            ST_TURN: begin
               state_s      = ST_RDATA;
               cnt_s        = '0;
               serial_oe_s  = 1'b1;
               serial_out_s = rd_sh_r[DATA_WIDTH-1];
               rd_sh_s      = {rd_sh_r[DATA_WIDTH-2:0], 1'b0};
            end
            ST_RDATA: begin
               if (cnt_r == DATA_LAST) begin
                  state_s      = ST_WAIT_REL;
                  serial_oe_s  = 1'b0;
                  serial_out_s = 1'b1;
               end else begin
                  cnt_s        = cnt_r + 1'b1;
                  serial_out_s = rd_sh_r[DATA_WIDTH-1];
                  rd_sh_s      = {rd_sh_r[DATA_WIDTH-2:0], 1'b0};
               end
            end
            ST_WAIT_REL: begin
               state_s = ST_WAIT_REL;
            end
            default: begin
               state_s      = ST_IDLE;
               cnt_s        = '0;
               req_valid_s  = 1'b0;
               serial_oe_s  = 1'b0;
               serial_out_s = 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_slave_serial_port.sv
// Frame-level bench for slave_serial_port: each frame is expanded into per-cycle stimulus and
// expected outputs from the bus protocol rules, then replayed and compared every cycle.
module tb_slave_serial_port;
   localparam int AW = 12, DW = 8, OFF = 0, SIZE = 2048, TO = 64;

   logic          clk = 1'b0, rstn = 1'b0;
   logic          serial_in = 1'b1, bus_busy = 1'b0, req_ack = 1'b0;
   logic [DW-1:0] rsp_rdata = '0;
   logic          serial_out, serial_oe, req_valid, req_rw, timeout_err;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;

   int n_tests = 0, n_fail = 0;

   typedef struct {
      logic          busy, ser, ack;
      logic [DW-1:0] rdata;
      logic          v, oe, sout, to;
      logic [AW-1:0] addr;
      logic          rw;
      logic [DW-1:0] wdata;
      logic          wchk;
   } step_t;
   step_t q[$];

   int            st_valid, st_oe, st_to;
   logic [DW-1:0] st_bits, st_wdata;
   logic [AW-1:0] st_addr;

   slave_serial_port #(.MEM_OFFSET(OFF), .MEM_SIZE(SIZE), .ADDRESS_WIDTH(AW),
                       .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rstn(rstn), .serial_in(serial_in), .bus_busy(bus_busy),
      .serial_out(serial_out), .serial_oe(serial_oe), .req_valid(req_valid),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
      .req_ack(req_ack), .rsp_rdata(rsp_rdata), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
      end
   endtask

   // Expand one frame. ack_dly: cycles after req_valid first shows until ack (-1 = never).
   // abort_at: frame step where bus_busy drops (-1 = none). stray_ack: ack high before REQ.
   task automatic build(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                        input int ack_dly, input logic [DW-1:0] rdata,
                        input int abort_at, input bit stray_ack);
      bit in_rng, acked, live;
      int v, a, last, k;
      step_t s;
      in_rng = (int'(addr) >= OFF) && (int'(addr) < OFF + SIZE);
      v      = AW + 1 + (wr ? DW : 0);
      acked  = in_rng && (ack_dly >= 1) && (ack_dly <= TO);
      a      = v + ack_dly;
      if (!in_rng)     last = AW + 1 + (wr ? DW : 0);
      else if (!acked) last = v + TO;
      else if (wr)     last = a;
      else             last = a + DW + 1;
      last = last + 2;
      if (abort_at >= 0 && abort_at < last) last = abort_at;
      for (int j = 0; j <= last + 1; j++) begin
         live   = !(abort_at >= 0 && j >= abort_at) && (j <= last);
         s.busy = live;
         if (j == 0)                       s.ser = 1'b0;
         else if (j <= AW)                 s.ser = addr[AW-j];
         else if (j == AW + 1)             s.ser = wr;
         else if (wr && j <= AW + 1 + DW)  s.ser = wdata[AW+1+DW-j];
         else                              s.ser = j[0];
         s.ack   = (acked && j == a) || (stray_ack && j < v);
         s.rdata = (acked && j == a) ? rdata : ~rdata;
         s.v     = in_rng && live && j >= v && j < (acked ? a : v + TO);
         s.to    = in_rng && live && !acked && j == v + TO;
         k       = j - a - 1;
         s.oe    = live && acked && !wr && k >= 0 && k < DW;
         s.sout  = s.oe ? rdata[DW-1-k] : 1'b1;
         s.addr  = addr;
         s.rw    = wr;
         s.wdata = wdata;
         s.wchk  = wr;
         q.push_back(s);
      end
   endtask

   task automatic play(input int max_steps);
      step_t s;
      st_valid = 0; st_oe = 0; st_to = 0; st_bits = '0; st_wdata = '0; st_addr = '0;
      for (int i = 0; i < max_steps && q.size() > 0; i++) begin
         s = q.pop_front();
         bus_busy = s.busy; serial_in = s.ser; req_ack = s.ack; rsp_rdata = s.rdata;
         @(posedge clk);
         #1;
         chk("req_valid", 32'(req_valid), 32'(s.v));
         chk("serial_oe", 32'(serial_oe), 32'(s.oe));
         chk("serial_out", 32'(serial_out), 32'(s.sout));
         chk("timeout_err", 32'(timeout_err), 32'(s.to));
         if (s.v) begin
            chk("req_addr", 32'(req_addr), 32'(s.addr));
            chk("req_rw", 32'(req_rw), 32'(s.rw));
            if (s.wchk) chk("req_wdata", 32'(req_wdata), 32'(s.wdata));
         end
         if (req_valid) begin
            st_valid++; st_addr = req_addr; st_wdata = req_wdata;
         end
         if (serial_oe) begin
            st_oe++; st_bits = {st_bits[DW-2:0], serial_out};
         end
         if (timeout_err) st_to++;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(req_valid), 32'd0);
      chk("rst_oe", 32'(serial_oe), 32'd0);
      chk("rst_out", 32'(serial_out), 32'd1);
      chk("rst_to", 32'(timeout_err), 32'd0);
      chk("rst_addr", 32'(req_addr), 32'd0);
      chk("rst_wdata", 32'(req_wdata), 32'd0);
      @(negedge clk) rstn = 1'b1;

      // Write frame, ack three cycles after the request appears
      build(12'h005, 1'b1, 8'hA5, 3, 8'h00, -1, 1'b0); play(1000);
      chk("t1_valid_cycles", st_valid, 32'd3);
      chk("t1_addr", 32'(st_addr), 32'h005);
      chk("t1_wdata", 32'(st_wdata), 32'hA5);
      chk("t1_no_drive", st_oe, 32'd0);

      // Read frame returning 0x3C
      build(12'h010, 1'b0, 8'h00, 2, 8'h3C, -1, 1'b0); play(1000);
      chk("t2_bits", 32'(st_bits), 32'h3C);
      chk("t2_drive_cycles", st_oe, 32'd8);

      // Out of range write with a stray ack
      build(12'h800, 1'b1, 8'h00, 1, 8'h00, -1, 1'b1); play(1000);
      chk("t3_no_req", st_valid, 32'd0);
      chk("t3_no_drive", st_oe, 32'd0);

      // Abort on the 4th address bit, then a read at the top of the window acked at the last cycle
      build(12'h123, 1'b1, 8'h5A, 2, 8'h00, 4, 1'b0); play(1000);
      chk("t4_no_req", st_valid, 32'd0);
      build(12'h7FF, 1'b0, 8'h00, TO, 8'h81, -1, 1'b0); play(1000);
      chk("t4_bits", 32'(st_bits), 32'h81);
      chk("t4_no_timeout", st_to, 32'd0);

      // Timeout on an unanswered read
      build(12'h010, 1'b0, 8'h00, -1, 8'h00, -1, 1'b0); play(1000);
      chk("t5_valid_cycles", st_valid, 32'd64);
      chk("t5_pulses", st_to, 32'd1);
      chk("t5_no_drive", st_oe, 32'd0);

      // Abort in the same cycle as the ack
      build(12'h020, 1'b0, 8'h00, 2, 8'hFF, AW + 3, 1'b0); play(1000);
      chk("t6_valid_cycles", st_valid, 32'd2);
      chk("t6_no_drive", st_oe, 32'd0);

      // Reset while read bit 3 is on the bus
      build(12'h030, 1'b0, 8'h00, 1, 8'hC3, -1, 1'b0); play(AW + 7);
      chk("t7_bits_before", 32'(st_bits), 32'h0C);
      #2 rstn = 1'b0;
      #1;
      chk("t7_oe", 32'(serial_oe), 32'd0);
      chk("t7_out", 32'(serial_out), 32'd1);
      chk("t7_valid", 32'(req_valid), 32'd0);
      q.delete();
      bus_busy = 1'b0; serial_in = 1'b1; req_ack = 1'b0;
      @(negedge clk) rstn = 1'b1;
      build(12'h7FF, 1'b1, 8'h3C, 1, 8'h00, -1, 1'b0); play(1000);
      chk("t7_after_valid", st_valid, 32'd1);
      chk("t7_after_wdata", 32'(st_wdata), 32'h3C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
